// File: rtl/mux_gate_arbiter.sv
// Round-robin arbiter sharing one mux-built bitwise logic unit among N_REQ requesters.
// One transaction at a time: IDLE (arbitrate) -> EXEC (compute) -> DONE (hold until res_ready).
module mux_gate_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 8,
   parameter int IDW   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [3*N_REQ-1:0]   op_flat,
   input  logic [W*N_REQ-1:0]   a_flat,
   input  logic [W*N_REQ-1:0]   b_flat,
   output logic [N_REQ-1:0]     grant,
   output logic                 busy,
   output logic                 res_valid,
   output logic [W-1:0]         res_data,
   output logic [IDW-1:0]       res_id,
   input  logic                 res_ready
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state_q;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     win_id_q;
   logic [2:0]         op_q;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [N_REQ-1:0]   grant_q;
   logic               res_valid_q;
   logic [W-1:0]       res_data_q;
   logic [IDW-1:0]     res_id_q;

   logic               found_d;
   logic [IDW-1:0]     winner_d;

   logic [2:0]         op_arr [N_REQ];
   logic [W-1:0]       a_arr  [N_REQ];
   logic [W-1:0]       b_arr  [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign op_arr[g] = op_flat[3*g +: 3];
      assign a_arr[g]  = a_flat[W*g +: W];
      assign b_arr[g]  = b_flat[W*g +: W];
   end

   // Each result bit is a 2:1 mux selected by a[i], choosing between two functions of b[i].
   function automatic logic [W-1:0] mux_unit(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W-1:0] y;
      logic         y0;
      logic         y1;
      y = '0;
      for (int i = 0; i < W; i++) begin
         y0 = 1'b0;
         y1 = 1'b0;
         case (op)
            3'b000: begin y0 = 1'b0;  y1 = b[i];  end
            3'b001: begin y0 = b[i];  y1 = 1'b1;  end
            3'b010: begin y0 = 1'b1;  y1 = ~b[i]; end
            3'b011: begin y0 = ~b[i]; y1 = 1'b0;  end
            3'b100: begin y0 = b[i];  y1 = ~b[i]; end
            3'b101: begin y0 = ~b[i]; y1 = b[i];  end
            3'b110: begin y0 = 1'b1;  y1 = 1'b0;  end
            default: begin y0 = 1'b0; y1 = 1'b1;  end
         endcase
         y[i] = a[i] ? y1 : y0;
      end
      return y;
   endfunction

   // Search starts at ptr and wraps, so the last winner is considered last.
   always_comb begin
      logic [IDW:0] sum;
      found_d  = 1'b0;
      winner_d = '0;
      sum      = '0;
      for (int off = 0; off < N_REQ; off++) begin
         sum = {1'b0, ptr_q} + (IDW+1)'(off);
         if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
         if (!found_d && req[sum[IDW-1:0]]) begin
            found_d  = 1'b1;
            winner_d = sum[IDW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         win_id_q    <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         grant_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= '0;
      end else begin
         grant_q <= '0;
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  op_q     <= op_arr[winner_d];
                  a_q      <= a_arr[winner_d];
                  b_q      <= b_arr[winner_d];
                  grant_q  <= N_REQ'(1) << winner_d;
                  win_id_q <= winner_d;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               res_data_q  <= mux_unit(op_q, a_q, b_q);
               res_id_q    <= win_id_q;
               res_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  ptr_q       <= (win_id_q == IDW'(N_REQ-1)) ? '0 : win_id_q + 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant     = grant_q;
   assign busy      = (state_q != IDLE);
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_mux_gate_arbiter.sv
// Directed testbench for mux_gate_arbiter: arbitration order, opcode results,
// backpressure, asynchronous reset and pointer wrap-around.
module tb_mux_gate_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] op_flat;
   logic [31:0] a_flat;
   logic [31:0] b_flat;
   logic [3:0]  grant;
   logic        busy;
   logic        res_valid;
   logic [7:0]  res_data;
   logic [1:0]  res_id;
   logic        res_ready;

   int total;
   int bad;

   mux_gate_arbiter #(.N_REQ(4), .W(8), .IDW(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .op_flat   (op_flat),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .grant     (grant),
      .busy      (busy),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_ready (res_ready)
   );

   // 10 ns clock; all sampling happens 1 ns after the rising edge
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [2:0] op,
                                input logic [7:0] a, input logic [7:0] b);
      op_flat[3*idx +: 3] = op;
      a_flat[8*idx +: 8]  = a;
      b_flat[8*idx +: 8]  = b;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset asynchronously, away from any clock edge
   task automatic pulseReset();
      rst = 1'b1;
      #1;
      checkOutput("rst_grant", 32'(grant), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_valid", 32'(res_valid), 32'h0);
      checkOutput("rst_data", 32'(res_data), 32'h0);
      checkOutput("rst_id", 32'(res_id), 32'h0);
      #1;
      rst = 1'b0;
   endtask

   // Grant cycle, result cycle, release cycle for one transaction with res_ready=1
   task automatic runTxn(input string tag, input logic [3:0] expGrant,
                         input logic [1:0] expId, input logic [7:0] expData,
                         input logic dropReq);
      stepCycle();
      checkOutput({tag, "_grant"}, 32'(grant), 32'(expGrant));
      checkOutput({tag, "_busy"}, 32'(busy), 32'h1);
      if (dropReq) req = 4'b0000;
      stepCycle();
      checkOutput({tag, "_grant_off"}, 32'(grant), 32'h0);
      checkOutput({tag, "_valid"}, 32'(res_valid), 32'h1);
      checkOutput({tag, "_id"}, 32'(res_id), 32'(expId));
      checkOutput({tag, "_data"}, 32'(res_data), 32'(expData));
      stepCycle();
      checkOutput({tag, "_released"}, 32'(res_valid), 32'h0);
      checkOutput({tag, "_idle"}, 32'(busy), 32'h0);
   endtask

   logic [7:0] sweepExp [8];

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      req       = '0;
      op_flat   = '0;
      a_flat    = '0;
      b_flat    = '0;
      res_ready = 1'b1;
      sweepExp  = '{8'h82, 8'hEE, 8'h7D, 8'h11, 8'h6C, 8'h93, 8'h55, 8'hAA};

      #2;
      pulseReset();

      // Single NOR request from requester 1; leaves ptr at 2
      applyStimulus(1, 3'b011, 8'hF0, 8'hCC);
      req = 4'b0010;
      runTxn("nor1", 4'b0010, 2'd1, 8'h03, 1'b1);
      applyStimulus(0, 3'b000, 8'hFF, 8'h11);
      applyStimulus(1, 3'b000, 8'hFF, 8'h22);
      applyStimulus(2, 3'b000, 8'hFF, 8'h33);
      applyStimulus(3, 3'b000, 8'hFF, 8'h44);
      req = 4'b1111;
      runTxn("ptr2", 4'b0100, 2'd2, 8'h33, 1'b0);

      // All requesters held high from reset: strict rotation 0,1,2,3,0
      #2;
      pulseReset();
      for (int k = 0; k < 5; k++) begin
         logic [7:0] rrData [4];
         rrData = '{8'h11, 8'h22, 8'h33, 8'h44};
         runTxn($sformatf("rr%0d", k), 4'(1 << (k % 4)), 2'(k % 4), rrData[k % 4], 1'b0);
      end

      // Opcode sweep on requester 0
      for (int op = 0; op < 8; op++) begin
         applyStimulus(0, 3'(op), 8'hAA, 8'hC6);
         req = 4'b0001;
         runTxn($sformatf("op%0d", op), 4'b0001, 2'd0, sweepExp[op], 1'b1);
      end

      // Backpressure: ptr is 1, so requester 1 wins and its result must hold
      req       = 4'b1111;
      res_ready = 1'b0;
      stepCycle();
      checkOutput("bp_grant", 32'(grant), 32'b0010);
      stepCycle();
      checkOutput("bp_valid", 32'(res_valid), 32'h1);
      for (int c = 0; c < 5; c++) begin
         stepCycle();
         checkOutput($sformatf("bp_hold_valid%0d", c), 32'(res_valid), 32'h1);
         checkOutput($sformatf("bp_hold_data%0d", c), 32'(res_data), 32'h22);
         checkOutput($sformatf("bp_hold_id%0d", c), 32'(res_id), 32'h1);
         checkOutput($sformatf("bp_no_grant%0d", c), 32'(grant), 32'h0);
         checkOutput($sformatf("bp_busy%0d", c), 32'(busy), 32'h1);
      end
      res_ready = 1'b1;
      stepCycle();
      checkOutput("bp_release_valid", 32'(res_valid), 32'h0);
      checkOutput("bp_release_idle", 32'(busy), 32'h0);
      runTxn("bp_next", 4'b0100, 2'd2, 8'h33, 1'b0);

      // Reset in EXEC (ptr was 3, requester 3 in flight)
      stepCycle();
      checkOutput("rx_grant", 32'(grant), 32'b1000);
      pulseReset();
      // Reset in DONE; the grant to requester 0 shows ptr returned to 0
      stepCycle();
      checkOutput("rd_grant", 32'(grant), 32'b0001);
      stepCycle();
      checkOutput("rd_valid", 32'(res_valid), 32'h1);
      pulseReset();
      req = 4'b1000;
      runTxn("post_rst", 4'b1000, 2'd3, 8'h44, 1'b1);

      // Move ptr to 3, then check wrap to requester 0 and completion after a dropped req
      req = 4'b0100;
      runTxn("to_ptr3", 4'b0100, 2'd2, 8'h33, 1'b1);
      req = 4'b0101;
      runTxn("wrap0", 4'b0001, 2'd0, 8'hAA, 1'b0);
      stepCycle();
      checkOutput("wrap2_grant", 32'(grant), 32'b0100);
      stepCycle();
      req = 4'b0000;
      checkOutput("drop_valid", 32'(res_valid), 32'h1);
      checkOutput("drop_id", 32'(res_id), 32'h2);
      checkOutput("drop_data", 32'(res_data), 32'h33);
      stepCycle();
      checkOutput("drop_released", 32'(res_valid), 32'h0);
      stepCycle();
      checkOutput("drop_no_grant", 32'(grant), 32'h0);
      checkOutput("drop_idle", 32'(busy), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
